// File: rtl/instr_mem_loader.sv
// Instruction memory with a valid/ready stream loader. Words are written at
// auto-incrementing addresses from a programmable base. A registered read port feeds fetch.
module instr_mem_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic [ADDR_W-1:0] i_load_base,
  input  logic [ADDR_W:0]   i_load_len,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_load_busy,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_load_count,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_err
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_clamped;
  logic              accept;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_err_q;

  // Memory has no reset so a reset mid-burst keeps the words already written.
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign len_clamped = (i_load_len > DepthCnt) ? DepthCnt : i_load_len;
  assign accept      = i_wr_valid & o_wr_ready;
  assign rd_ok       = i_rd_en & (state_q != StLoad);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    count_d     = count_q;
    o_wr_ready  = 1'b0;
    o_load_busy = 1'b0;
    o_load_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_load_start) begin
          ptr_d   = i_load_base;
          len_d   = len_clamped;
          count_d = '0;
          state_d = (len_clamped == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        o_wr_ready  = 1'b1;
        o_load_busy = 1'b1;
        if (i_wr_valid) begin
          ptr_d   = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == len_q - 1'b1) state_d = StDone;
        end
      end
      StDone: begin
        o_load_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
      rd_err_q   <= i_rd_en & (state_q == StLoad);
      if (rd_ok) rd_data_q <= mem_q[i_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem_q[ptr_q] <= i_wr_data;
  end

  assign o_load_count = count_q;
  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_err     = rd_err_q;

endmodule
